// File: rtl/phase_sequencer.sv
// ----------------------------------------------------------------------------
// phase_sequencer
//   Control FSM that drives the instruction-decoder phase strobes fe/e1/e2.
//   Each instruction is fetched and then runs E1. Only instructions the
//   decoder flags with extra1 also run E2.
//   The sequencer halts on STP, when run is dropped, after a single step, or
//   (optionally) on a PC breakpoint. It inserts wait states while instruction
//   or data memory is not ready, and it counts retired instructions.
//
//   Optional feature macro: BREAKPOINT_EN
//     defined   -> halt before fetching the instruction at bp_addr.
//     undefined -> bp_enable, bp_addr and pc are ignored; bp_hit is tied 0.
//
// Ports
//   clk          in   1      system clock, rising edge
//   reset        in   1      asynchronous, active-high
//   run          in   1      level; rising edge starts, low halts at boundary
//   step         in   1      1-cycle pulse; in HALT runs exactly one instruction
//   mem_wait     in   1      memory not ready (fetch or E2 data access)
//   extra1       in   1      current instruction needs E2
//   is_stp       in   1      current instruction is STP
//   clr_count    in   1      synchronous clear of instr_count (wins over +1)
//   pc           in   PC_W   current program counter (breakpoint compare)
//   bp_enable    in   1      breakpoint armed
//   bp_addr      in   PC_W   breakpoint address
//   fe/e1/e2     out  1      phase strobes, Moore decodes of the state
//   halted       out  1      1 while in HALT
//   stp_seen     out  1      last halt caused by STP; clears on leaving HALT
//   bp_hit       out  1      last halt caused by breakpoint; clears on leaving
//   state        out  3      HALT=0 FETCH=1 EXEC1=2 DWAIT=3 EXEC2=4
//   instr_count  out  CNT_W  retired non-STP instructions, wraps to 0
// ----------------------------------------------------------------------------
module phase_sequencer #(
  parameter int CNT_W = 16,
  parameter int PC_W  = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  input  logic             mem_wait,
  input  logic             extra1,
  input  logic             is_stp,
  input  logic             clr_count,
  input  logic [PC_W-1:0]  pc,
  input  logic             bp_enable,
  input  logic [PC_W-1:0]  bp_addr,
  output logic             fe,
  output logic             e1,
  output logic             e2,
  output logic             halted,
  output logic             stp_seen,
  output logic             bp_hit,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_HALT  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC1 = 3'd2,
    S_DWAIT = 3'd3,
    S_EXEC2 = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic             r_run_q;
  logic             r_single;
  logic             r_stp_seen;
  logic             r_bp_hit;
  logic             r_bp_supp;
  logic [CNT_W-1:0] r_count;

  logic w_start;
  logic w_boundary;
  logic w_leave_halt;
  logic w_single_nxt;
  logic w_stp_set;
  logic w_bp_set;
  logic w_bp_match;

  // A start is a rising edge of run, seen against last cycle's sample.
  assign w_start = run & ~r_run_q;

`ifdef BREAKPOINT_EN
  // The first boundary after leaving HALT is exempt, so resuming from a
  // breakpoint executes the breakpointed instruction instead of re-halting.
  assign w_bp_match = bp_enable && (pc == bp_addr) && !r_bp_supp;
  assign bp_hit     = r_bp_hit;
`else
  logic w_bp_unused;
  assign w_bp_match  = 1'b0;
  assign bp_hit      = 1'b0;
  assign w_bp_unused = ^{bp_enable, bp_addr, pc, r_bp_supp, r_bp_hit};
`endif

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_boundary   = 1'b0;
    w_leave_halt = 1'b0;
    w_single_nxt = r_single;
    w_stp_set    = 1'b0;
    w_bp_set     = 1'b0;

    case (r_state)
      S_HALT: begin
        if (w_start) begin
          // Start wins over a simultaneous step: free run, no single-step.
          w_state_nxt  = S_FETCH;
          w_single_nxt = 1'b0;
          w_leave_halt = 1'b1;
        end else if (step) begin
          w_state_nxt  = S_FETCH;
          w_single_nxt = 1'b1;
          w_leave_halt = 1'b1;
        end
      end
      S_FETCH: begin
        if (!mem_wait) w_state_nxt = S_EXEC1;
      end
      S_EXEC1: begin
        if (is_stp) begin
          w_state_nxt = S_HALT;
          w_stp_set   = 1'b1;
        end else if (!extra1) begin
          w_boundary = 1'b1;
        end else if (mem_wait) begin
          w_state_nxt = S_DWAIT;
        end else begin
          w_state_nxt = S_EXEC2;
        end
      end
      S_DWAIT: begin
        // Waiting here instead of holding EXEC2 keeps e2 a single pulse.
        if (!mem_wait) w_state_nxt = S_EXEC2;
      end
      S_EXEC2: begin
        w_boundary = 1'b1;
      end
      default: begin
        w_state_nxt = S_HALT;
      end
    endcase

    if (w_boundary) begin
      if (r_single || !run) begin
        w_state_nxt = S_HALT;
      end else if (w_bp_match) begin
        w_state_nxt = S_HALT;
        w_bp_set    = 1'b1;
      end else begin
        w_state_nxt = S_FETCH;
      end
    end

    if ((w_state_nxt == S_HALT) && (r_state != S_HALT)) w_single_nxt = 1'b0;
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_HALT;
      r_run_q    <= 1'b0;
      r_single   <= 1'b0;
      r_stp_seen <= 1'b0;
      r_bp_hit   <= 1'b0;
      r_bp_supp  <= 1'b0;
      r_count    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_run_q  <= run;
      r_single <= w_single_nxt;

      if (w_leave_halt) begin
        r_stp_seen <= 1'b0;
        r_bp_hit   <= 1'b0;
      end else begin
        if (w_stp_set) r_stp_seen <= 1'b1;
        if (w_bp_set)  r_bp_hit   <= 1'b1;
      end

      if (w_leave_halt)    r_bp_supp <= 1'b1;
      else if (w_boundary) r_bp_supp <= 1'b0;

      if (clr_count)       r_count <= '0;
      else if (w_boundary) r_count <= r_count + CNT_ONE;
    end
  end

  assign fe          = (r_state == S_FETCH);
  assign e1          = (r_state == S_EXEC1);
  assign e2          = (r_state == S_EXEC2);
  assign halted      = (r_state == S_HALT);
  assign stp_seen    = r_stp_seen;
  assign state       = r_state;
  assign instr_count = r_count;

endmodule

// File: tb/tb_phase_sequencer.sv
// ----------------------------------------------------------------------------
// tb_phase_sequencer
//   Directed bench for phase_sequencer. Stimulus is written one instruction
//   at a time: fetch waits, extra1, data waits and STP. An instruction-level
//   model turns each instruction into the state timeline it must produce.
//   It also tracks the retired count, the sticky flags and the halt decisions
//   taken at instruction boundaries. One compare process checks every cycle
//   against that timeline. Literal checks at key points pin the model.
//   The counter is built 6 bits wide so that wrap-around is reachable quickly.
// ----------------------------------------------------------------------------
module tb_phase_sequencer;

  localparam int CNT_W = 6;
  localparam int PC_W  = 11;

  localparam logic [2:0] HALT  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] EXEC1 = 3'd2;
  localparam logic [2:0] DWAIT = 3'd3;
  localparam logic [2:0] EXEC2 = 3'd4;

  logic             clk = 1'b0;
  logic             reset;
  logic             run, step, mem_wait, extra1, is_stp, clr_count, bp_enable;
  logic [PC_W-1:0]  pc, bp_addr;
  logic             fe, e1, e2, halted, stp_seen, bp_hit;
  logic [2:0]       state;
  logic [CNT_W-1:0] instr_count;

  phase_sequencer #(.CNT_W(CNT_W), .PC_W(PC_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .step        (step),
    .mem_wait    (mem_wait),
    .extra1      (extra1),
    .is_stp      (is_stp),
    .clr_count   (clr_count),
    .pc          (pc),
    .bp_enable   (bp_enable),
    .bp_addr     (bp_addr),
    .fe          (fe),
    .e1          (e1),
    .e2          (e2),
    .halted      (halted),
    .stp_seen    (stp_seen),
    .bp_hit      (bp_hit),
    .state       (state),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] st;
    bit         stp;
    bit         bp;
    int         cnt;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_err    = 0;

  // Model state
  int         m_count;
  bit         m_ss, m_stp, m_bp, m_supp, m_run_prev;
  logic [2:0] m_state;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, req, $time);
    end
  endtask

  // Compare process: one expectation per clock edge, sampled after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!reset && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("state", 32'(state), 32'(e.st));
        check("strobes", 32'({fe, e1, e2, halted}),
              32'({e.st == FETCH, e.st == EXEC1, e.st == EXEC2, e.st == HALT}));
        check("flags", 32'({stp_seen, bp_hit}), 32'({e.stp, e.bp}));
        check("count", 32'(instr_count), 32'(e.cnt));
      end
    end
  end

  // One clock: record what the DUT must show after the next edge.
  task automatic step_cyc(input logic [2:0] nxt, input bit retire);
    if (clr_count)   m_count = 0;
    else if (retire) m_count = (m_count + 1) % (1 << CNT_W);
    m_run_prev = run;
    m_state    = nxt;
    exp_q.push_back('{nxt, m_stp, m_bp, m_count});
    @(negedge clk);
  endtask

  // End of a non-STP instruction: retire, then decide halt or next fetch.
  task automatic boundary();
    bit h;
    h = m_ss || !run;
`ifdef BREAKPOINT_EN
    if (!h && bp_enable && (pc == bp_addr) && !m_supp) begin
      h    = 1'b1;
      m_bp = 1'b1;
    end
`endif
    m_supp = 1'b0;
    if (h) m_ss = 1'b0;
    step_cyc(h ? HALT : FETCH, 1'b1);
  endtask

  // One cycle spent in HALT with the current run/step inputs.
  task automatic halt_cyc();
    bit leave;
    leave = 1'b0;
    if (run && !m_run_prev) begin
      m_ss  = 1'b0;
      leave = 1'b1;
    end else if (step) begin
      m_ss  = 1'b1;
      leave = 1'b1;
    end
    if (leave) begin
      m_stp  = 1'b0;
      m_bp   = 1'b0;
      m_supp = 1'b1;
      step_cyc(FETCH, 1'b0);
    end else begin
      step_cyc(HALT, 1'b0);
    end
  endtask

  // One instruction, starting with the DUT in FETCH.
  //   fw: fetch wait cycles, x1: extra1, dw: data wait cycles, stp: STP.
  task automatic instr(input int fw, input bit x1, input int dw, input bit stp);
    extra1 = x1;
    is_stp = stp;
    for (int i = 0; i < fw; i++) begin
      mem_wait = 1'b1;
      step_cyc(FETCH, 1'b0);
    end
    mem_wait = 1'b0;
    step_cyc(EXEC1, 1'b0);
    mem_wait = (dw > 0);
    if (stp) begin
      m_stp = 1'b1;
      m_ss  = 1'b0;
      step_cyc(HALT, 1'b0);
    end else if (!x1) begin
      boundary();
    end else begin
      if (dw > 0) begin
        for (int i = 0; i < dw; i++) step_cyc(DWAIT, 1'b0);
        mem_wait = 1'b0;
      end
      step_cyc(EXEC2, 1'b0);
      boundary();
    end
    extra1   = 1'b0;
    is_stp   = 1'b0;
    mem_wait = 1'b0;
  endtask

  task automatic model_reset();
    m_count    = 0;
    m_ss       = 1'b0;
    m_stp      = 1'b0;
    m_bp       = 1'b0;
    m_supp     = 1'b0;
    m_run_prev = 1'b0;
    m_state    = HALT;
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; step = 1'b0; mem_wait = 1'b0; extra1 = 1'b0;
    is_stp = 1'b0; clr_count = 1'b0; bp_enable = 1'b0;
    pc = '0; bp_addr = 11'h010;
    model_reset();

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_state", 32'(state), 32'd0);
    check("rst_halted", 32'(halted), 32'd1);
    check("rst_strobes", 32'({fe, e1, e2}), 32'd0);
    check("rst_count", 32'(instr_count), 32'd0);
    check("rst_flags", 32'({stp_seen, bp_hit}), 32'd0);
    reset = 1'b0;
    halt_cyc();
    halt_cyc();

    // Free run: short instructions, then waits of each kind
    run = 1'b1;
    halt_cyc();
    instr(0, 0, 0, 0);
    instr(0, 0, 0, 0);
    check("cnt_two", 32'(instr_count), 32'd2);
    check("fetch_after_two", 32'(state), 32'(FETCH));
    instr(0, 1, 3, 0);              // EXEC1, DWAIT x3, EXEC2
    instr(2, 0, 0, 0);              // fetch waits
    instr(0, 0, 2, 0);              // mem_wait without extra1: no DWAIT
    step = 1'b1;                    // step outside HALT is ignored
    instr(1, 1, 0, 0);
    step = 1'b0;
    check("cnt_six", 32'(instr_count), 32'd6);

    // STP overrides extra1 and mem_wait; no retire, no e2
    instr(0, 1, 1, 1);
    check("stp_seen_lit", 32'(stp_seen), 32'd1);
    check("stp_halt", 32'(state), 32'(HALT));
    check("stp_cnt", 32'(instr_count), 32'd6);
    repeat (3) halt_cyc();          // run held high: no restart

    // Single step with run held high still stops after one instruction
    step = 1'b1;
    halt_cyc();
    step = 1'b0;
    instr(1, 1, 1, 0);
    check("step_halt", 32'(state), 32'(HALT));
    check("step_cnt", 32'(instr_count), 32'd7);
    check("step_stp_clr", 32'(stp_seen), 32'd0);
    halt_cyc();

    // run re-edge restarts
    run = 1'b0;
    halt_cyc();
    run = 1'b1;
    halt_cyc();
    instr(0, 0, 0, 0);

    // run drop halts at the boundary
    run = 1'b0;
    instr(0, 1, 1, 0);
    check("drop_halt", 32'(halted), 32'd1);
    check("drop_cnt", 32'(instr_count), 32'd9);
    halt_cyc();

    // step and run rising together: free run
    run  = 1'b1;
    step = 1'b1;
    halt_cyc();
    step = 1'b0;
    instr(0, 0, 0, 0);
    instr(0, 0, 0, 0);
    check("free_run", 32'(state), 32'(FETCH));
    check("cnt_eleven", 32'(instr_count), 32'd11);

    // Wrap: all-ones -> 0, then clear on the same edge as a retire
    repeat (63 - 11) instr(0, 0, 0, 0);
    check("cnt_max", 32'(instr_count), 32'h3F);
    instr(0, 0, 0, 0);
    check("cnt_wrap", 32'(instr_count), 32'd0);
    repeat (63) instr(0, 0, 0, 0);
    clr_count = 1'b1;
    instr(0, 0, 0, 0);
    clr_count = 1'b0;
    check("cnt_clr_retire", 32'(instr_count), 32'd0);

    // Breakpoint at 010 (ignored when the feature is not built)
    bp_enable = 1'b1;
    pc = 11'h00F;
    instr(0, 0, 0, 0);
    pc = 11'h010;
    instr(0, 0, 0, 0);
    if (m_state == HALT) begin
      check("bp_hit_lit", 32'(bp_hit), 32'd1);
      check("bp_halted", 32'(state), 32'(HALT));
      run = 1'b0;
      halt_cyc();
      run = 1'b1;
      halt_cyc();
    end else begin
      check("bp_tied_off", 32'(bp_hit), 32'd0);
    end
    instr(0, 0, 0, 0);              // resume executes the instruction at 010
    pc = 11'h011;
    instr(0, 0, 0, 0);
    check("bp_resumed", 32'(state), 32'(FETCH));
    bp_enable = 1'b0;

    // Asynchronous reset in the middle of EXEC2
    extra1 = 1'b1;
    step_cyc(EXEC1, 1'b0);
    step_cyc(EXEC2, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("arst_state", 32'(state), 32'd0);
    check("arst_strobes", 32'({fe, e1, e2, halted}), 32'b0001);
    check("arst_count", 32'(instr_count), 32'd0);
    @(negedge clk);
    reset  = 1'b0;
    run    = 1'b0;
    extra1 = 1'b0;
    model_reset();
    halt_cyc();
    run = 1'b1;
    halt_cyc();
    instr(0, 0, 0, 0);
    run = 1'b0;
    instr(0, 1, 0, 0);
    check("post_rst_cnt", 32'(instr_count), 32'd2);
    halt_cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
